// File: rtl/calc_token_sequencer_pkg.sv
// Shared definitions for the calculator token sequencer: opcode values,
// FSM state encoding and the opcode decode helpers. The calculator uses
// the same opcode values.
package calc_token_sequencer_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned OP_W   = 3;

   localparam logic [OP_W-1:0] OP_ZERO   = 3'b000;
   localparam logic [OP_W-1:0] OP_SHOW_A = 3'b001;
   localparam logic [OP_W-1:0] OP_SHOW_B = 3'b010;
   localparam logic [OP_W-1:0] OP_ADD    = 3'b011;
   localparam logic [OP_W-1:0] OP_SUB    = 3'b100;

   typedef enum logic [1:0] {
      S_A    = 2'd0,   // waiting for operand A
      S_OP   = 2'd1,   // waiting for an operator
      S_B    = 2'd2,   // waiting for operand B
      S_EXEC = 2'd3    // calculator inputs stable, result captured next edge
   } state_t;

   // Opcodes the calculator implements.
   function automatic logic op_is_valid(input logic [OP_W-1:0] op);
      return (op == OP_ZERO)   || (op == OP_SHOW_A) || (op == OP_SHOW_B) ||
             (op == OP_ADD)    || (op == OP_SUB);
   endfunction

   // Opcodes that do not need operand B.
   function automatic logic op_is_unary(input logic [OP_W-1:0] op);
      return (op == OP_ZERO) || (op == OP_SHOW_A);
   endfunction

endpackage

// File: rtl/calc_token_sequencer_if.sv
// Bundle of the token input stream, the calculator operand/result wires
// and the latched result/status outputs of the sequencer.
interface calc_token_sequencer_if;
   import calc_token_sequencer_pkg::*;

   // token stream
   logic              tok_valid;
   logic              tok_is_op;
   logic [DATA_W-1:0] tok_data;
   logic              tok_ready;

   // calculator side
   logic [DATA_W-1:0] entrada_A;
   logic [DATA_W-1:0] entrada_B;
   logic [OP_W-1:0]   codigo;
   logic [DATA_W-1:0] saida;

   // result side
   logic [DATA_W-1:0] result;
   logic              result_valid;
   logic              error;

   // Environment: token source, calculator and result consumer.
   modport master (
      output tok_valid, tok_is_op, tok_data, saida,
      input  tok_ready, entrada_A, entrada_B, codigo,
      input  result, result_valid, error
   );

   // The sequencer itself.
   modport slave (
      input  tok_valid, tok_is_op, tok_data, saida,
      output tok_ready, entrada_A, entrada_B, codigo,
      output result, result_valid, error
   );

endinterface

// File: rtl/calc_token_sequencer.sv
// Token sequencer in front of the 8-bit combinational calculator: collects
// A / operator / B tokens into registers driving the calculator, then
// latches the calculator output one cycle later with a valid pulse.
module calc_token_sequencer
   import calc_token_sequencer_pkg::*;
#(
   parameter bit CHAIN = 1'b1   // 1: result becomes the next operand A
) (
   input  logic                     clk,
   input  logic                     rst_n,
   calc_token_sequencer_if.slave    bus
);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              result_valid_q, result_valid_d;
   logic              error_q, error_d;

   logic              accept;
   logic [OP_W-1:0]   tok_op;

   // Token handshake and opcode field extraction.
   always_comb begin
      accept = bus.tok_valid && (state_q != S_EXEC);
      tok_op = bus.tok_data[OP_W-1:0];
   end

   // Next-state and register update logic; pulses default low each cycle.
   always_comb begin
      state_d        = state_q;
      a_d            = a_q;
      b_d            = b_q;
      op_d           = op_q;
      result_d       = result_q;
      result_valid_d = 1'b0;
      error_d        = 1'b0;

      unique case (state_q)
         S_A: begin
            if (accept) begin
               if (bus.tok_is_op) begin
                  error_d = 1'b1;
               end else begin
                  a_d     = bus.tok_data;
                  state_d = S_OP;
               end
            end
         end

         S_OP: begin
            if (accept) begin
               if (!bus.tok_is_op) begin
                  a_d = bus.tok_data;
               end else if (!op_is_valid(tok_op)) begin
                  error_d = 1'b1;
               end else begin
                  op_d    = tok_op;
                  state_d = op_is_unary(tok_op) ? S_EXEC : S_B;
               end
            end
         end

         S_B: begin
            if (accept) begin
               if (bus.tok_is_op) begin
                  error_d = 1'b1;
               end else begin
                  b_d     = bus.tok_data;
                  state_d = S_EXEC;
               end
            end
         end

         S_EXEC: begin
            result_d       = bus.saida;
            result_valid_d = 1'b1;
            if (CHAIN) begin
               a_d     = bus.saida;
               op_d    = OP_ZERO;
               state_d = S_OP;
            end else begin
               state_d = S_A;
            end
         end

         default: begin
            state_d = S_A;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= S_A;
         a_q            <= '0;
         b_q            <= '0;
         op_q           <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         error_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         a_q            <= a_d;
         b_q            <= b_d;
         op_q           <= op_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         error_q        <= error_d;
      end
   end

   // Drive the interface outputs from the registers.
   always_comb begin
      bus.tok_ready    = (state_q != S_EXEC);
      bus.entrada_A    = a_q;
      bus.entrada_B    = b_q;
      bus.codigo       = op_q;
      bus.result       = result_q;
      bus.result_valid = result_valid_q;
      bus.error        = error_q;
   end

endmodule
